// File: rtl/buf_cmd_fifo_pkg.sv
// buf_cmd_fifo_pkg: command word layout and opcode constants shared by the command buffer and executor
package buf_cmd_fifo_pkg;
    localparam int CMD_WIDTH = 40;
    localparam int OP_MSB    = 39;
    localparam int OP_LSB    = 38;
    localparam int SUB_MSB   = 37;
    localparam int SUB_LSB   = 32;

    typedef enum logic [1:0] {
        OP_WRITE_REG = 2'b01,
        OP_MISC      = 2'b10
    } op_t;

    typedef enum logic [5:0] {
        MISC_NOP      = 6'd0,
        MISC_STB      = 6'd1,
        MISC_WAIT_ALL = 6'd2,
        MISC_WAIT_ANY = 6'd3,
        MISC_CLEAR    = 6'd4,
        MISC_DONE     = 6'd63
    } misc_t;
endpackage

// File: rtl/buf_sdp_ram.sv
// buf_sdp_ram: simple dual-port block RAM, sync write, sync read with enable, no reset
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata registered read word.
module buf_sdp_ram #(
    parameter int W  = 40,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/buf_cmd_fifo.sv
// buf_cmd_fifo: packs 32-bit host writes into 40-bit commands and buffers them in a block-RAM FIFO
// Ports: clk, rst (async high); in_data/in_hi/in_lo host writes; clear flush; upstream_count;
//        full/overflow/underflow status; fifo_read/fifo_empty/fifo_data executor side;
//        fifo_local_count and fifo_global_count fill levels.
module buf_cmd_fifo
    import buf_cmd_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_data,
    input  logic                 in_hi,
    input  logic                 in_lo,
    input  logic                 clear,
    input  logic [31:0]          upstream_count,
    output logic                 full,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 fifo_read,
    output logic                 fifo_empty,
    output logic [CMD_WIDTH-1:0] fifo_data,
    output logic [31:0]          fifo_local_count,
    output logic [31:0]          fifo_global_count
);
    localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   count, count_next;
    logic [7:0]            hi_latch;
    logic                  push, rd, data_valid;
    logic [CMD_WIDTH-1:0]  ram_q;

    assign push = in_lo && !full && !clear;
    assign rd   = fifo_read && !fifo_empty && !clear;
    assign count_next = (push && !rd) ? count + 1'b1 : (rd && !push) ? count - 1'b1 : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            hi_latch   <= '0;
            full       <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            data_valid <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            hi_latch   <= '0;
            full       <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (rd) data_valid <= 1'b1;
            if (in_hi) hi_latch <= in_data[7:0];
            if (in_lo && full) overflow <= 1'b1;
            if (fifo_read && fifo_empty) underflow <= 1'b1;
            count      <= count_next;
            full       <= count_next == DEPTH;
            fifo_empty <= count_next == '0;
        end
    end

    buf_sdp_ram #(.W(CMD_WIDTH), .AW(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata ({hi_latch, in_data}),
        .re    (rd),
        .raddr (rptr),
        .rdata (ram_q)
    );

    // The RAM output register has no reset, so mask it until the first read lands.
    assign fifo_data         = data_valid ? ram_q : '0;
    assign fifo_local_count  = {{(31-DEPTH_LOG2){1'b0}}, count};
    assign fifo_global_count = fifo_local_count + upstream_count;
endmodule

// File: tb/tb_buf_cmd_fifo.sv
// tb_buf_cmd_fifo: directed self-checking bench for buf_cmd_fifo
module tb_buf_cmd_fifo;
    logic        clk = 0, rst = 0;
    logic [31:0] in_data = 0, upstream_count = 0;
    logic        in_hi = 0, in_lo = 0, clear = 0, fifo_read = 0;
    logic        full, overflow, underflow, fifo_empty;
    logic [39:0] fifo_data;
    logic [31:0] fifo_local_count, fifo_global_count;
    int passed = 0, total = 0;

    buf_cmd_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_hi(in_hi), .in_lo(in_lo),
        .clear(clear), .upstream_count(upstream_count), .full(full), .overflow(overflow),
        .underflow(underflow), .fifo_read(fifo_read), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_local_count(fifo_local_count),
        .fifo_global_count(fifo_global_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_hi(input logic [7:0] b);
        in_hi = 1; in_data = {24'h0, b}; tick(); in_hi = 0;
    endtask

    task automatic push(input logic [31:0] d);
        in_lo = 1; in_data = d; tick(); in_lo = 0;
    endtask

    task automatic pop;
        fifo_read = 1; tick(); fifo_read = 0;
    endtask

    task automatic do_clear;
        clear = 1; tick(); clear = 0;
    endtask

    task automatic test_reset;
        rst = 1; #2; rst = 0; tick();
        total++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", fifo_empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
        total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {overflow, underflow}); else passed++;
        total++; if (fifo_data !== 40'h0) $display("FAIL reset_data got %h want 0", fifo_data); else passed++;
        total++; if (fifo_local_count !== 32'd0) $display("FAIL reset_count got %0d want 0", fifo_local_count); else passed++;
    endtask

    task automatic test_pack;
        set_hi(8'h41); push(32'h5); push(32'h6);
        total++; if (fifo_local_count !== 32'd2) $display("FAIL pack_count got %0d want 2", fifo_local_count); else passed++;
        pop();
        total++; if (fifo_data !== 40'h41_0000_0005) $display("FAIL pack_word0 got %h want 4100000005", fifo_data); else passed++;
        pop();
        total++; if (fifo_data !== 40'h41_0000_0006) $display("FAIL pack_word1 got %h want 4100000006", fifo_data); else passed++;
        total++; if (fifo_empty !== 1'b1) $display("FAIL pack_empty got %b want 1", fifo_empty); else passed++;
    endtask

    task automatic test_fill_overflow;
        do_clear(); set_hi(8'h12);
        for (int i = 0; i < 16; i++) push(32'h100 + i);
        total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else passed++;
        total++; if (fifo_local_count !== 32'd16) $display("FAIL fill_count got %0d want 16", fifo_local_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_early got %b want 0", overflow); else passed++;
        push(32'hDEAD);
        total++; if (overflow !== 1'b1) $display("FAIL fill_ovf got %b want 1", overflow); else passed++;
        total++; if (fifo_local_count !== 32'd16) $display("FAIL fill_count17 got %0d want 16", fifo_local_count); else passed++;
        for (int i = 0; i < 16; i++) begin
            pop();
            total++; if (fifo_data !== 40'h12_0000_0100 + 40'(i)) $display("FAIL fill_data%0d got %h want %h", i, fifo_data, 40'h12_0000_0100 + 40'(i)); else passed++;
        end
        total++; if ({fifo_empty, full, overflow} !== 3'b101) $display("FAIL fill_after got %b want 101", {fifo_empty, full, overflow}); else passed++;
    endtask

    task automatic test_simul;
        do_clear(); push(32'hA); push(32'hB); push(32'hC);
        in_lo = 1; in_data = 32'hD; fifo_read = 1; tick(); in_lo = 0; fifo_read = 0;
        total++; if (fifo_local_count !== 32'd3) $display("FAIL simul_count got %0d want 3", fifo_local_count); else passed++;
        total++; if (fifo_data !== 40'h00_0000_000A) $display("FAIL simul_data got %h want 000000000a", fifo_data); else passed++;
    endtask

    task automatic test_empty_read;
        do_clear();
        pop();
        total++; if (underflow !== 1'b1) $display("FAIL udf got %b want 1", underflow); else passed++;
        total++; if (fifo_data !== 40'h00_0000_000A) $display("FAIL udf_hold got %h want 000000000a", fifo_data); else passed++;
        do_clear();
        total++; if (underflow !== 1'b0) $display("FAIL udf_clr got %b want 0", underflow); else passed++;
        in_lo = 1; in_data = 32'h77; fifo_read = 1; tick(); in_lo = 0; fifo_read = 0;
        total++; if (underflow !== 1'b1) $display("FAIL udf_push got %b want 1", underflow); else passed++;
        total++; if (fifo_local_count !== 32'd1) $display("FAIL udf_push_count got %0d want 1", fifo_local_count); else passed++;
        total++; if (fifo_data !== 40'h00_0000_000A) $display("FAIL udf_push_hold got %h want 000000000a", fifo_data); else passed++;
        pop();
        total++; if (fifo_data !== 40'h00_0000_0077) $display("FAIL udf_push_word got %h want 0000000077", fifo_data); else passed++;
    endtask

    task automatic test_wrap_global;
        do_clear(); upstream_count = 100;
        push(32'h200); push(32'h201); push(32'h202);
        for (int i = 0; i < 20; i++) begin
            in_lo = 1; in_data = 32'h203 + i; fifo_read = 1; tick();
            total++; if (fifo_data !== 40'h200 + 40'(i)) $display("FAIL wrap_data%0d got %h want %h", i, fifo_data, 40'h200 + 40'(i)); else passed++;
        end
        in_lo = 0; fifo_read = 0;
        total++; if (fifo_global_count !== 32'd103) $display("FAIL global got %0d want 103", fifo_global_count); else passed++;
        upstream_count = 32'hFFFF_FFFF; #1;
        total++; if (fifo_global_count !== 32'd2) $display("FAIL global_wrap got %0d want 2", fifo_global_count); else passed++;
        upstream_count = 0;
    endtask

    task automatic test_clear;
        do_clear(); pop(); set_hi(8'h55);
        for (int i = 0; i < 5; i++) push(32'h300 + i);
        clear = 1; in_lo = 1; in_data = 32'h99; tick(); clear = 0; in_lo = 0;
        total++; if (fifo_local_count !== 32'd0) $display("FAIL clr_count got %0d want 0", fifo_local_count); else passed++;
        total++; if ({fifo_empty, full, overflow, underflow} !== 4'b1000) $display("FAIL clr_flags got %b want 1000", {fifo_empty, full, overflow, underflow}); else passed++;
        push(32'h1); pop();
        total++; if (fifo_data !== 40'h00_0000_0001) $display("FAIL clr_hi got %h want 0000000001", fifo_data); else passed++;
    endtask

    task automatic test_async_rst;
        set_hi(8'h66); in_lo = 1;
        for (int i = 0; i < 4; i++) begin in_data = 32'h400 + i; tick(); end
        #2; rst = 1; in_lo = 0; #1;
        total++; if ({fifo_empty, full} !== 2'b10) $display("FAIL rst_flags got %b want 10", {fifo_empty, full}); else passed++;
        total++; if (fifo_local_count !== 32'd0) $display("FAIL rst_count got %0d want 0", fifo_local_count); else passed++;
        total++; if (fifo_data !== 40'h0) $display("FAIL rst_data got %h want 0", fifo_data); else passed++;
        rst = 0;
        push(32'h5);
        total++; if (fifo_local_count !== 32'd1) $display("FAIL rst_push_count got %0d want 1", fifo_local_count); else passed++;
        pop();
        total++; if (fifo_data !== 40'h00_0000_0005) $display("FAIL rst_word got %h want 0000000005", fifo_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_pack();
        test_fill_overflow();
        test_simul();
        test_empty_read();
        test_wrap_global();
        test_clear();
        test_async_rst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
